// File: rtl/rom_reader_pkg.sv
// Shared types and constants for the sequential ROM read initiator.
package rom_reader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/rom_reader_fifo.sv
// Two-entry FIFO holding ROM words plus their end-of-burst marker.
module rom_reader_fifo
    import rom_reader_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push,
    input  logic           pop,
    input  logic [WIDTH:0] din,
    output logic [WIDTH:0] dout,
    output logic           full,
    output logic           empty,
    output logic [1:0]     occupancy
);

    logic [WIDTH:0] mem [FIFO_DEPTH];
    logic           wr_ptr;
    logic           rd_ptr;
    logic [1:0]     level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            level  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   level <= level + 2'd1;
                2'b01:   level <= level - 2'd1;
                default: level <= level;
            endcase
        end
    end

    assign dout      = mem[rd_ptr];
    assign full      = (level == 2'd2);
    assign empty     = (level == 2'd0);
    assign occupancy = level;

endmodule

// File: rtl/rom_reader.sv
// Walks a ROM address range and streams the words out on valid/ready,
// hiding the ROM's one-cycle read latency behind a two-entry FIFO.
module rom_reader
    import rom_reader_pkg::*;
#(
    parameter int ASIZE = 12,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ASIZE-1:0] base_addr,
    input  logic [ASIZE:0]   count,
    output logic             busy,
    output logic             done,
    output logic             rom_en,
    output logic [ASIZE-1:0] rom_addr,
    input  logic [WIDTH-1:0] rom_dout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last
);

    state_t           state;
    state_t           state_next;
    logic [ASIZE-1:0] base_p0;
    logic [ASIZE:0]   count_p0;
    logic [ASIZE:0]   issued;
    logic [ASIZE:0]   sent;
    logic             vld_p1;
    logic             last_p1;

    logic             pop;
    logic             issue_last;
    logic             slot_free;
    logic             drain_empty;
    logic             finish;
    logic [2:0]       level_next;

    logic [WIDTH:0]   fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [1:0]       fifo_occ;

    assign pop        = out_valid & out_ready;
    assign issue_last = ((issued + {{ASIZE{1'b0}}, 1'b1}) == count_p0);
    assign rom_addr   = base_p0 + issued[ASIZE-1:0];
    assign busy       = (state != IDLE);

    // Words already buffered or on their way back must leave room for this issue.
    assign level_next = {1'b0, fifo_occ} + {2'b00, vld_p1} - {2'b00, pop};
    assign slot_free  = (level_next < 3'd2) && !(fifo_full && vld_p1);

    // Look ahead to the state after this cycle's pop so done follows the last handshake directly.
    assign drain_empty = fifo_empty || ((fifo_occ == 2'd1) && pop);
    assign finish      = (state == DRAIN) && !vld_p1 && drain_empty &&
                         ((sent + {{ASIZE{1'b0}}, pop}) == count_p0);

    always_comb begin
        state_next = state;
        rom_en     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (count == '0) ? DRAIN : RUN;
                end
            end
            RUN: begin
                if ((issued < count_p0) && slot_free) begin
                    rom_en = 1'b1;
                    if (issue_last) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (finish) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Stage p0: burst parameters and counters; stage p1: ROM read in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            base_p0  <= '0;
            count_p0 <= '0;
            issued   <= '0;
            sent     <= '0;
            vld_p1   <= 1'b0;
            last_p1  <= 1'b0;
            done     <= 1'b0;
        end else begin
            state   <= state_next;
            done    <= finish;
            vld_p1  <= rom_en;
            last_p1 <= rom_en && issue_last;
            if ((state == IDLE) && start) begin
                base_p0  <= base_addr;
                count_p0 <= count;
                issued   <= '0;
                sent     <= '0;
            end else begin
                if (rom_en) begin
                    issued <= issued + {{ASIZE{1'b0}}, 1'b1};
                end
                if (pop) begin
                    sent <= sent + {{ASIZE{1'b0}}, 1'b1};
                end
            end
        end
    end

    // Stage p2: returned word parked in the output FIFO.
    rom_reader_fifo #(
        .WIDTH(WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (vld_p1),
        .pop       (pop),
        .din       ({last_p1, rom_dout}),
        .dout      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .occupancy (fifo_occ)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_head[WIDTH-1:0];
    assign out_last  = fifo_head[WIDTH];

endmodule
